// File: rtl/aes_state_buffer_if.sv
// Byte stream bundle for the AES state buffer.
// master drives load/drain controls; slave is the buffer.
interface aes_state_buffer_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       shift_rows_en;
  logic       flush;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    output in_byte,
    output in_valid,
    output shift_rows_en,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_byte,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    input  shift_rows_en,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_byte,
    output out_valid,
    output busy
  );
endinterface

// File: rtl/aes_state_buffer.sv
// 16-byte AES state buffer: byte-serial load, natural/ShiftRows drain.
// Ports: clk, rst (async high), bus (slave: in/out byte handshakes, flush, busy).
module aes_state_buffer (
  input  logic clk,
  input  logic rst,
  aes_state_buffer_if.slave bus
);
  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] mem [16];
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic       sr_mode;

  logic [1:0] rd_row;
  logic [1:0] rd_col;
  logic [1:0] src_col;
  logic [3:0] src;

  // ShiftRows: row r is rotated left by r columns, so output
  // column c row r reads from column (c + r) mod 4.
  assign rd_row  = rd_ptr[1:0];
  assign rd_col  = rd_ptr[3:2];
  assign src_col = rd_col + rd_row;
  assign src     = sr_mode ? {src_col, rd_row} : rd_ptr;

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_byte  = (state == DRAIN) ? mem[src] : 8'h00;
  assign bus.busy      = (state == DRAIN) || (wr_ptr != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      sr_mode <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (bus.flush) begin
      state   <= LOAD;
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      sr_mode <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (bus.in_valid) begin
            mem[wr_ptr] <= bus.in_byte;
            wr_ptr      <= wr_ptr + 4'd1;
            if (wr_ptr == 4'd15) begin
              sr_mode <= bus.shift_rows_en;
              rd_ptr  <= 4'd0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            rd_ptr <= rd_ptr + 4'd1;
            if (rd_ptr == 4'd15) begin
              state <= LOAD;
            end
          end
        end
      endcase
    end
  end
endmodule
